pixel_sink: RTL and testbench
=============================

Name: pixel_sink

Overview:
- Terminating end of the pixel-write stream produced by the sprite/ship drawing engines (x, y, color, writeEn per pixel).
- Clips off-screen and transparent pixels and converts (x,y) to a linear framebuffer address.
- Buffers pixels in a small FIFO and drives a ready/valid write port into the framebuffer memory.
- Also provides a full-screen clear sweep, ordered strictly after pixels already accepted.

Parameters:
- SCREEN_W, 160, visible width in pixels
- SCREEN_H, 120, visible height in pixels
- ADDR_W, 15, framebuffer address width; must satisfy 2^ADDR_W >= SCREEN_W*SCREEN_H
- FIFO_DEPTH, 4, pixel FIFO entries (power of two)
- SKIP_TRANSPARENT, 1, when 1, pixels whose color equals TRANSPARENT are dropped
- TRANSPARENT, 3'b000, transparent colour code

Ports:
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- x  in  10  pixel column from draw engine
- y  in  10  pixel row from draw engine
- color  in  3  pixel colour
- writeEn  in  1  pixel valid, one pixel per cycle, no backpressure to source
- clear_start  in  1  one-cycle request to clear the whole screen
- clear_color  in  3  fill colour, sampled on every clear beat
- mem_address  out  ADDR_W  framebuffer write address
- mem_data  out  3  framebuffer write colour
- mem_we  out  1  write valid
- mem_ready  in  1  memory accepts a write this cycle when mem_we && mem_ready
- busy  out  1  high in FLUSH or CLEAR
- clear_done  out  1  one-cycle pulse on the final clear beat
- overflow  out  1  sticky: an accepted pixel was lost to a full FIFO

Behaviour:
- Reset (asynchronous, reset_n=0): state IDLE; FIFO empty; clear counter 0; flush count 0; clear pending 0. Outputs mem_we=0, mem_address=0, mem_data=0, busy=0, clear_done=0, overflow=0. Reset mid-clear or mid-flush aborts the sweep with no further writes.
- Input qualification (every cycle with writeEn=1): the pixel is accepted iff x<SCREEN_W, y<SCREEN_H, and not (SKIP_TRANSPARENT && color==TRANSPARENT). Rejected pixels are silently discarded.
- Push: an accepted pixel enqueues {y*SCREEN_W+x truncated to ADDR_W, color} at the clock edge.
- Full FIFO: the push is still taken if a pop happens in the same cycle. Otherwise the pixel is dropped and overflow is set. overflow clears only on reset or on clear_start.
- Pop: occurs on any cycle with mem_we && mem_ready while FIFO data is presented.
- States: IDLE, FLUSH, CLEAR.
- IDLE: mem_we = FIFO non-empty; address and data come from the FIFO head. On clear_start, snapshot N = FIFO occupancy after this cycle's push and pop, then go to FLUSH if N>0, else CLEAR.
- FLUSH: same output as IDLE. Each pop decrements N; go to CLEAR on the pop that makes N=0. Pixels arriving during FLUSH queue behind the snapshot.
- CLEAR: mem_we=1, mem_address=counter, mem_data=clear_color. On each mem_ready=1 the counter increments. At counter==SCREEN_W*SCREEN_H-1 with mem_ready=1: clear_done=1 that cycle, counter returns to 0, next state IDLE.
- The FIFO keeps accepting pushes during CLEAR; those pixels drain after the sweep.
- clear_start while busy is ignored.
- Latency: writeEn at cycle t, IDLE, FIFO empty → mem_we=1 with that pixel at t+1. Throughput is 1 pixel/cycle while mem_ready=1.
- mem_address and mem_data are held stable while mem_we=1 && mem_ready=0.
- Arithmetic: y*SCREEN_W uses a constant multiply, at least 17 bits wide before truncation. Coordinate comparisons are unsigned on 10 bits.

Decomposition:
- Shared draw package holds: SCREEN_W, SCREEN_H, ADDR_W, colour width (3), TRANSPARENT, and the state encodings IDLE/FLUSH/CLEAR.
- One sub-module, pixel_fifo: synchronous FIFO parameterised by width/depth, with push, pop, head, empty, full and count outputs, plus simultaneous push/pop when full.
- Qualification, address computation and the FSM live in pixel_sink.

Test Plan:
- mem_ready=1; x=5,y=2,color=3'b100,writeEn=1 for one cycle → next cycle mem_we=1, mem_address=325, mem_data=3'b100; mem_we=0 after.
- Pixels (160,0,3'b001), (0,120,3'b001), (10,10,3'b000) → no mem_we ever asserted; overflow stays 0.
- mem_ready=0; 5 consecutive valid pixels at x=0..4,y=0 → overflow=1; after mem_ready=1, exactly addresses 0,1,2,3 are written, in order.
- Simultaneous push/pop: FIFO full, mem_ready=1, one new pixel (7,1) → accepted; overflow stays 0; address 167 is written last.
- Two pixels queued (addr 325, 326), mem_ready=0, pulse clear_start with clear_color=3'b010 → busy=1; after mem_ready=1, writes go 325, 326, then 0..19199 with data 3'b010; clear_done pulses on address 19199; busy=0 next cycle.
- Assert reset_n=0 at clear address 1000 → outputs return to reset values asynchronously; after release, IDLE with no writes until new input.

Source files
------------

// File: rtl/pixel_sink_pkg.sv
// Shared drawing constants, state encoding and screen geometry for the pixel sink.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pixel_sink_pkg;

  // Visible screen geometry and framebuffer address width
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int ADDR_W   = 15;
  localparam int NPIX     = SCREEN_W * SCREEN_H;

  // Colour format and transparency handling
  localparam int                 COLOR_W          = 3;
  localparam logic [COLOR_W-1:0] TRANSPARENT      = 3'b000;
  localparam bit                 SKIP_TRANSPARENT = 1'b1;

  // Pixel FIFO depth (power of two)
  localparam int FIFO_DEPTH = 4;

  // Sink controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

endpackage

// File: rtl/pixel_sink_if.sv
// Framebuffer write channel: address/colour with valid (mem_we) and ready (mem_ready).
// Latency: n/a (wires only).
// Backpressure: master holds address/data stable while mem_we && !mem_ready.
interface pixel_sink_if;
  import pixel_sink_pkg::*;

  logic [ADDR_W-1:0]  mem_address;
  logic [COLOR_W-1:0] mem_data;
  logic               mem_we;
  logic               mem_ready;

  // Pixel sink side: drives writes, observes memory readiness
  modport master (
    output mem_address,
    output mem_data,
    output mem_we,
    input  mem_ready
  );

  // Framebuffer memory side
  modport slave (
    input  mem_address,
    input  mem_data,
    input  mem_we,
    output mem_ready
  );

endinterface

// File: rtl/pixel_sink_fifo.sv
// Generic synchronous FIFO with head-of-queue output and occupancy count.
// Latency: a push is visible at o_head the cycle after it is written.
// Backpressure: push while full is dropped unless a pop happens the same cycle.
module pixel_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_dat,
  output logic [WIDTH-1:0]           o_head,
  output logic                       o_empty,
  output logic                       o_full,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop_ok;
  logic             w_push_ok;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_pop_ok  = i_pop && !o_empty;
  // A full FIFO still takes a push when the head leaves in the same cycle
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  // Storage write; contents need no reset since reads are gated by occupancy
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_dat;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop_ok);
    end
  end

endmodule

// File: rtl/pixel_sink.sv
// Clips/queues draw-engine pixels and writes them to the framebuffer; also runs ordered screen clears.
// Latency: accepted pixel appears on the write port one cycle later when the queue is empty.
// Backpressure: none to the pixel source (full queue drops and flags overflow); memory stalls via mem_ready.
module pixel_sink
  import pixel_sink_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  input  logic [COLOR_W-1:0] color,
  input  logic               writeEn,
  input  logic               clear_start,
  input  logic [COLOR_W-1:0] clear_color,
  pixel_sink_if.master       mem,
  output logic               busy,
  output logic               clear_done,
  output logic               overflow
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int PIX_W = ADDR_W + COLOR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ADDR_W-1:0]  r_clr_cnt;
  logic [CNT_W-1:0]   r_flush_cnt;
  logic               r_overflow;

  logic               w_accept;
  logic [ADDR_W-1:0]  w_addr;
  logic               w_pop;
  logic               w_push_ok;
  logic               w_empty;
  logic               w_full;
  logic [CNT_W-1:0]   w_count;
  logic [CNT_W-1:0]   w_count_after;
  logic [PIX_W-1:0]   w_head;
  logic               w_clear_go;

  // On-screen, non-transparent pixels only; comparisons are unsigned 10-bit
  assign w_accept = writeEn
                 && (x < 10'(SCREEN_W))
                 && (y < 10'(SCREEN_H))
                 && !(SKIP_TRANSPARENT && (color == TRANSPARENT));

  // Linear address: 20-bit product keeps the full row offset before truncation
  assign w_addr = ADDR_W'(({10'd0, y} * 20'(SCREEN_W)) + {10'd0, x});

  // The queue only drains outside the clear sweep
  assign w_pop         = (r_state != ST_CLEAR) && !w_empty && mem.mem_ready;
  assign w_push_ok     = w_accept && (!w_full || w_pop);
  assign w_count_after = w_count + CNT_W'(w_push_ok) - CNT_W'(w_pop);
  assign w_clear_go    = (r_state == ST_IDLE) && clear_start;
  assign overflow      = r_overflow;

  pixel_fifo #(
    .WIDTH (PIX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_accept),
    .i_pop   (w_pop),
    .i_dat   ({w_addr, color}),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (w_count)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and write-port outputs; the port reads zero whenever mem_we is low
  always_comb begin
    w_state_nxt     = r_state;
    mem.mem_we      = 1'b0;
    mem.mem_address = '0;
    mem.mem_data    = '0;
    busy            = 1'b0;
    clear_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          mem.mem_we      = 1'b1;
          mem.mem_address = w_head[PIX_W-1:COLOR_W];
          mem.mem_data    = w_head[COLOR_W-1:0];
        end
        if (clear_start) begin
          w_state_nxt = (w_count_after != '0) ? ST_FLUSH : ST_CLEAR;
        end
      end
      ST_FLUSH: begin
        busy = 1'b1;
        if (!w_empty) begin
          mem.mem_we      = 1'b1;
          mem.mem_address = w_head[PIX_W-1:COLOR_W];
          mem.mem_data    = w_head[COLOR_W-1:0];
        end
        if (w_pop && (r_flush_cnt == CNT_W'(1))) begin
          w_state_nxt = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        busy            = 1'b1;
        mem.mem_we      = 1'b1;
        mem.mem_address = r_clr_cnt;
        mem.mem_data    = clear_color;
        if (mem.mem_ready && (r_clr_cnt == LAST_ADDR)) begin
          clear_done  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Count of pixels that must drain before the sweep: snapshot on clear, decrement per pop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_flush_cnt <= '0;
    end else if (w_clear_go) begin
      r_flush_cnt <= w_count_after;
    end else if ((r_state == ST_FLUSH) && w_pop) begin
      r_flush_cnt <= r_flush_cnt - 1'b1;
    end
  end

  // Clear sweep address, advanced on each accepted beat and wrapped after the last pixel
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clr_cnt <= '0;
    end else if ((r_state == ST_CLEAR) && mem.mem_ready) begin
      if (r_clr_cnt == LAST_ADDR) begin
        r_clr_cnt <= '0;
      end else begin
        r_clr_cnt <= r_clr_cnt + 1'b1;
      end
    end
  end

  // Sticky overflow: a new drop wins over a simultaneous clear request
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
    end else if (w_accept && w_full && !w_pop) begin
      r_overflow <= 1'b1;
    end else if (w_clear_go) begin
      r_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pixel_sink.sv
// Directed bench for pixel_sink: queue-level reference model checked every cycle plus literal expectations.
// Latency: n/a.
// Backpressure: bench drives mem_ready directly.
module tb_pixel_sink;
  import pixel_sink_pkg::*;

  logic       clk;
  logic       reset_n;
  logic [9:0] x;
  logic [9:0] y;
  logic [2:0] color;
  logic       writeEn;
  logic       clear_start;
  logic [2:0] clear_color;
  logic       busy;
  logic       clear_done;
  logic       overflow;

  pixel_sink_if mif ();

  pixel_sink dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .x           (x),
    .y           (y),
    .color       (color),
    .writeEn     (writeEn),
    .clear_start (clear_start),
    .clear_color (clear_color),
    .mem         (mif),
    .busy        (busy),
    .clear_done  (clear_done),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Log of writes the memory actually accepted
  int log_a[$];
  int log_d[$];

  function automatic int log_at(input int i);
    if (i < log_a.size()) return log_a[i];
    return -1;
  endfunction

  // Reference model: the queue of pixels waiting for memory, plus an outstanding clear
  typedef struct {
    int a;
    int c;
  } ent_t;
  ent_t m_q[$];
  bit   m_clear;
  int   m_before;
  int   m_idx;
  bit   m_ovf;

  always @(negedge clk) begin
    bit   sweeping;
    bit   was_busy;
    bit   pop;
    bit   acc;
    int   e_we, e_a, e_d, e_done;
    ent_t e;
    if (!reset_n) begin
      m_q.delete();
      m_clear  = 0;
      m_before = 0;
      m_idx    = 0;
      m_ovf    = 0;
    end else begin
      sweeping = m_clear && (m_before == 0);
      was_busy = m_clear;
      e_we = 0; e_a = 0; e_d = 0;
      if (sweeping) begin
        e_we = 1; e_a = m_idx; e_d = clear_color;
      end else if (m_q.size() > 0) begin
        e_we = 1; e_a = m_q[0].a; e_d = m_q[0].c;
      end
      e_done = (sweeping && mif.mem_ready && m_idx == NPIX - 1) ? 1 : 0;
      chk("mem_we", mif.mem_we, e_we);
      chk("mem_address", mif.mem_address, e_a);
      chk("mem_data", mif.mem_data, e_d);
      chk("busy", busy, was_busy);
      chk("clear_done", clear_done, e_done);
      chk("overflow", overflow, m_ovf);
      if (mif.mem_we && mif.mem_ready) begin
        log_a.push_back(mif.mem_address);
        log_d.push_back(mif.mem_data);
      end
      // Advance the model by this cycle's inputs
      pop = !sweeping && (m_q.size() > 0) && mif.mem_ready;
      acc = writeEn && (x < SCREEN_W) && (y < SCREEN_H) && (color != 3'b000);
      if (pop) begin
        void'(m_q.pop_front());
        if (m_before > 0) m_before--;
      end
      if (sweeping && mif.mem_ready) begin
        if (m_idx == NPIX - 1) begin
          m_clear = 0;
          m_idx   = 0;
        end else begin
          m_idx++;
        end
      end
      if (clear_start && !was_busy) begin
        m_ovf = 0;
      end
      if (acc) begin
        if (m_q.size() < FIFO_DEPTH) begin
          e.a = y * SCREEN_W + x;
          e.c = color;
          m_q.push_back(e);
        end else begin
          m_ovf = 1;
        end
      end
      if (clear_start && !was_busy) begin
        m_before = m_q.size();
        m_clear  = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int px, input int py, input int pc);
    x = 10'(px); y = 10'(py); color = 3'(pc); writeEn = 1'b1;
    tick();
    writeEn = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_we"}, mif.mem_we, 0);
    chk({tag, "_addr"}, mif.mem_address, 0);
    chk({tag, "_data"}, mif.mem_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, clear_done, 0);
    chk({tag, "_ovf"}, overflow, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int found;
    int sb;
    reset_n = 1'b0; x = '0; y = '0; color = '0; writeEn = 1'b0;
    clear_start = 1'b0; clear_color = '0; mif.mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    reset_n = 1'b1;
    tick();

    // Single pixel, one-cycle latency
    log_a.delete(); log_d.delete();
    x = 10'd5; y = 10'd2; color = 3'b100; writeEn = 1'b1;
    tick();
    writeEn = 1'b0;
    chk("t1_we", mif.mem_we, 1);
    chk("t1_addr", mif.mem_address, 325);
    chk("t1_data", mif.mem_data, 4);
    tick();
    chk("t1_we_after", mif.mem_we, 0);
    tick();
    chk("t1_count", log_a.size(), 1);

    // Clipped and transparent pixels never reach memory
    log_a.delete(); log_d.delete();
    pix(160, 0, 1);
    pix(0, 120, 1);
    pix(10, 10, 0);
    repeat (3) tick();
    chk("t2_count", log_a.size(), 0);
    chk("t2_ovf", overflow, 0);

    // Stalled memory: fifth pixel overflows, first four drain in order
    log_a.delete(); log_d.delete();
    mif.mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) pix(i, 0, 1);
    chk("t3_ovf", overflow, 1);
    mif.mem_ready = 1'b1;
    repeat (6) tick();
    chk("t3_count", log_a.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t3_addr%0d", i), log_at(i), i);

    // Clear ordered after two queued pixels
    log_a.delete(); log_d.delete();
    mif.mem_ready = 1'b0;
    pix(5, 2, 1);
    pix(6, 2, 1);
    clear_color = 3'b010; clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    chk("t5_busy", busy, 1);
    mif.mem_ready = 1'b1;
    found = 0;
    for (int i = 0; i < 20000; i++) begin
      if (clear_done) begin
        found = 1;
        break;
      end
      tick();
    end
    chk("t5_done_seen", found, 1);
    chk("t5_done_addr", mif.mem_address, 19199);
    tick();
    chk("t5_busy_after", busy, 0);
    chk("t5_ovf_cleared", overflow, 0);
    chk("t5_count", log_a.size(), 2 + NPIX);
    chk("t5_first", log_at(0), 325);
    chk("t5_second", log_at(1), 326);
    sb = 0;
    for (int i = 0; i < NPIX; i++) begin
      if (i + 2 >= log_a.size()) begin
        sb++;
      end else if (log_a[i+2] != i || log_d[i+2] != 2) begin
        sb++;
      end
    end
    chk("t5_sweep_bad_beats", sb, 0);

    // Full FIFO with simultaneous pop takes the new pixel
    log_a.delete(); log_d.delete();
    mif.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) pix(i, 1, 5);
    mif.mem_ready = 1'b1;
    pix(7, 1, 5);
    repeat (8) tick();
    chk("t4_count", log_a.size(), 5);
    for (int i = 0; i < 4; i++) chk($sformatf("t4_addr%0d", i), log_at(i), 160 + i);
    chk("t4_last", log_at(4), 167);
    chk("t4_ovf", overflow, 0);

    // Reset in the middle of a sweep
    clear_color = 3'b110; clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    found = 0;
    for (int i = 0; i < 2000; i++) begin
      if (busy && mif.mem_address == 15'd1000) begin
        found = 1;
        break;
      end
      tick();
    end
    chk("t6_reached_1000", found, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("t6_async");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    log_a.delete(); log_d.delete();
    repeat (10) tick();
    chk("t6_no_writes", log_a.size(), 0);
    chk("t6_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
